// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the sequential 64x64 multiplier controller.
// Step shifts are expressed in units of HALF_W so any half-width can reuse them.
package mul_seq_pkg;

  localparam int HALF_W_DEF = 32;
  localparam int NUM_STEPS  = 4;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t MUL  = 2'd1;
  localparam state_t DONE = 2'd2;

  // Shift applied to each step's partial product, in multiples of HALF_W.
  function automatic int unsigned step_shift_units(input logic [2:0] step);
    case (step)
      3'd0:       return 0;
      3'd1, 3'd2: return 1;
      3'd3:       return 2;
      default:    return 0;
    endcase
  endfunction

endpackage

// File: rtl/mul_32x32.sv
// Combinational W x W -> 2W unsigned multiplier shared by every partial-product step.
module mul_32x32 #(
  parameter int W = 32
) (
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [2*W-1:0] p_o
);

  assign p_o = (2*W)'(a_i) * (2*W)'(b_i);

endmodule

// File: rtl/mul64_seq_ctrl.sv
// Iterative 64x64 unsigned multiplier: four partial products through one shared multiplier.
// Define MUL_PIPE_EN to register the product before accumulation (one extra MUL cycle).
module mul64_seq_ctrl
  import mul_seq_pkg::*;
#(
  parameter int HALF_W = HALF_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2*HALF_W-1:0] x,
  input  logic [2*HALF_W-1:0] y,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*HALF_W-1:0] out,
  output logic                busy
);

  localparam int OP_W  = 2 * HALF_W;
  localparam int RES_W = 4 * HALF_W;

  state_t          state_q, state_d;
  logic [2:0]      step_q, step_d;
  logic [RES_W-1:0] acc_q, acc_d;
  logic [OP_W-1:0] x_q, x_d, y_q, y_d;

  logic [HALF_W-1:0] a_op, b_op;
  logic [OP_W-1:0]   pp;
  logic [OP_W-1:0]   acc_pp;
  logic [2:0]        acc_step;
  logic              acc_en;
  logic [2:0]        last_step;
  logic [RES_W-1:0]  pp_shifted;

  // Step bit 1 picks the x half, bit 0 the y half: xl*yl, xl*yh, xh*yl, xh*yh.
  assign a_op = step_q[1] ? x_q[OP_W-1:HALF_W] : x_q[HALF_W-1:0];
  assign b_op = step_q[0] ? y_q[OP_W-1:HALF_W] : y_q[HALF_W-1:0];

  mul_32x32 #(.W(HALF_W)) u_mul (
    .a_i (a_op),
    .b_i (b_op),
    .p_o (pp)
  );

`ifdef MUL_PIPE_EN
  logic [OP_W-1:0] pp_q;

  // Issue step k while accumulating the registered product of step k-1.
  always_ff @(posedge clk) begin
    if (rst) pp_q <= '0;
    else     pp_q <= pp;
  end

  assign acc_pp    = pp_q;
  assign acc_step  = step_q - 3'd1;
  assign acc_en    = (step_q != 3'd0);
  assign last_step = 3'(NUM_STEPS);
`else
  assign acc_pp    = pp;
  assign acc_step  = step_q;
  assign acc_en    = 1'b1;
  assign last_step = 3'(NUM_STEPS - 1);
`endif

  assign pp_shifted = {{OP_W{1'b0}}, acc_pp} << (step_shift_units(acc_step) * HALF_W);

  always_comb begin
    // NOTE: every next-state signal takes its hold value first so no path infers a latch.
    state_d = state_q;
    step_d  = step_q;
    acc_d   = acc_q;
    x_d     = x_q;
    y_d     = y_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = MUL;
          x_d     = x;
          y_d     = y;
          acc_d   = '0;
          step_d  = '0;
        end
      end
      MUL: begin
        if (acc_en) acc_d = acc_q + pp_shifted;
        step_d = step_q + 3'd1;
        if (step_q == last_step) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers update with non-blocking assignments only.
    if (rst) begin
      state_q <= IDLE;
      step_q  <= '0;
      acc_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      acc_q   <= acc_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out       = acc_q;

endmodule
